// File: rtl/simd_pkg.sv
// Shared constants, instruction field slices, opcode and FSM state encodings
// for the SIMD instruction sequencer.
package simd_pkg;

  localparam int INS_WIDTH      = 64;
  localparam int INS_ADDR_WIDTH = 11;
  localparam int INS_DEPTH      = 2048;
  localparam int LOOP_CNT_WIDTH = 16;

  localparam int OPC_MSB = 63;
  localparam int OPC_LSB = 60;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  // Opcodes 0x1..0xB are all compute instructions forwarded to the PE array
  typedef enum logic [3:0] {
    OPC_NOP       = 4'h0,
    OPC_CMP_FIRST = 4'h1,
    OPC_CMP_LAST  = 4'hB,
    OPC_LOOP      = 4'hC,
    OPC_ENDL      = 4'hD,
    OPC_RSVD      = 4'hE,
    OPC_HALT      = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DECODE = 3'd3,
    ST_ISSUE  = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_e;

endpackage

// File: rtl/simd_loop_ctrl.sv
// Single-level hardware loop bookkeeping: remembers the loop body start and
// remaining trip count, and tells the sequencer when ENDL must branch back.
module simd_loop_ctrl
  import simd_pkg::*;
(
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      clear,
  input  logic                      do_loop,
  input  logic                      do_endl,
  input  logic [LOOP_CNT_WIDTH-1:0] imm,
  input  logic [INS_ADDR_WIDTH-1:0] pc,
  output logic                      loop_active,
  output logic [INS_ADDR_WIDTH-1:0] loop_start,
  output logic                      take_back
);

  logic [LOOP_CNT_WIDTH-1:0] loop_cnt;

  assign take_back = loop_active && (loop_cnt > LOOP_CNT_WIDTH'(1));

  // A zero trip count still executes the body once
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      loop_active <= 1'b0;
      loop_cnt    <= '0;
      loop_start  <= '0;
    end else if (clear) begin
      loop_active <= 1'b0;
      loop_cnt    <= '0;
      loop_start  <= '0;
    end else if (do_loop) begin
      loop_active <= 1'b1;
      loop_start  <= pc + 1'b1;
      loop_cnt    <= (imm == '0) ? LOOP_CNT_WIDTH'(1) : imm;
    end else if (do_endl) begin
      if (take_back) begin
        loop_cnt <= loop_cnt - 1'b1;
      end else begin
        loop_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/simd_instr_sequencer.sv
// Fetch/decode/issue controller feeding the SIMD PE array from instruction BRAM.
// Optional SIMD_SEQ_PERF_EN adds saturating cycle_cnt/issue_cnt run counters.
module simd_instr_sequencer
  import simd_pkg::*;
(
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_data_valid,
  input  logic                      stall,
  output logic                      ins_en,
  output logic [INS_ADDR_WIDTH-1:0] ins_addr,
  input  logic [INS_WIDTH-1:0]      ins_dout,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [INS_WIDTH-1:0]      issue_instr,
  output logic                      out_data_valid,
  output logic                      err
`ifdef SIMD_SEQ_PERF_EN
  ,
  output logic [31:0]               cycle_cnt,
  output logic [31:0]               issue_cnt
`endif
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_FETCH  = ST_FETCH;
  localparam logic [2:0] S_WAIT   = ST_WAIT;
  localparam logic [2:0] S_DECODE = ST_DECODE;
  localparam logic [2:0] S_ISSUE  = ST_ISSUE;
  localparam logic [2:0] S_DONE   = ST_DONE;

  logic [2:0]                state;
  logic [INS_ADDR_WIDTH-1:0] pc;
  logic [INS_WIDTH-1:0]      instr_q;
  logic [3:0]                opcode;
  logic                      run_start;
  logic                      issue_accept;
  logic                      advance;
  logic                      pc_last;
  logic                      loop_active;
  logic [INS_ADDR_WIDTH-1:0] loop_start;
  logic                      take_back;
  logic                      do_loop;
  logic                      do_endl;

  assign opcode         = instr_q[OPC_MSB:OPC_LSB];
  assign run_start      = (state == S_IDLE) && in_data_valid;
  assign issue_accept   = (state == S_ISSUE) && issue_ready && !stall;
  assign pc_last        = (pc == INS_ADDR_WIDTH'(INS_DEPTH - 1));
  assign do_loop        = (state == S_DECODE) && (opcode == OPC_LOOP) && !loop_active;
  assign do_endl        = (state == S_DECODE) && (opcode == OPC_ENDL);

  assign ins_en         = (state == S_FETCH);
  assign ins_addr       = pc;
  assign issue_valid    = (state == S_ISSUE);
  assign out_data_valid = (state == S_DONE);

  simd_loop_ctrl u_loop_ctrl (
    .clk         (clk),
    .rstn        (rstn),
    .clear       (run_start),
    .do_loop     (do_loop),
    .do_endl     (do_endl),
    .imm         (instr_q[IMM_MSB:IMM_LSB]),
    .pc          (pc),
    .loop_active (loop_active),
    .loop_start  (loop_start),
    .take_back   (take_back)
  );

  // Every sequential step to pc+1 funnels through here so the overrun check is in one place
  always_comb begin
    advance = 1'b0;
    if (state == S_DECODE) begin
      case (opcode)
        OPC_NOP, OPC_RSVD: advance = 1'b1;
        OPC_LOOP:          advance = !loop_active;
        OPC_ENDL:          advance = !take_back;
        default:           advance = 1'b0;
      endcase
    end else if (state == S_ISSUE) begin
      advance = issue_accept;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      pc          <= '0;
      instr_q     <= '0;
      issue_instr <= '0;
      err         <= 1'b0;
    end else if (advance) begin
      if (pc_last) begin
        err   <= 1'b1;
        state <= S_DONE;
      end else begin
        pc    <= pc + 1'b1;
        state <= S_FETCH;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (in_data_valid) begin
            pc    <= '0;
            err   <= 1'b0;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          instr_q <= ins_dout;
          state   <= S_DECODE;
        end
        S_DECODE: begin
          if (opcode == OPC_HALT) begin
            state <= S_DONE;
          end else if (opcode == OPC_LOOP) begin
            err   <= 1'b1;
            state <= S_DONE;
          end else if (opcode == OPC_ENDL) begin
            pc    <= loop_start;
            state <= S_FETCH;
          end else begin
            issue_instr <= instr_q;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_ISSUE;
        S_DONE: begin
          if (!in_data_valid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SIMD_SEQ_PERF_EN
  // Counters restart with each run and freeze once DONE is reached
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_cnt <= '0;
      issue_cnt <= '0;
    end else if (run_start) begin
      cycle_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if ((state != S_IDLE) && (state != S_DONE) && (cycle_cnt != '1)) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end
      if (issue_accept && (issue_cnt != '1)) begin
        issue_cnt <= issue_cnt + 1'b1;
      end
    end
  end
`endif

endmodule
